// File: rtl/cpu_hazard_pkg.sv
// cpu_hazard_pkg: opcodes, FSM encoding and scoreboard entry type shared by the hazard controller
package cpu_hazard_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_SW    = 6'h2B;
  typedef enum logic [1:0] {
    HZ_IDLE  = 2'd0,
    HZ_RUN   = 2'd1,
    HZ_STALL = 2'd2,
    HZ_FLUSH = 2'd3
  } hz_state_t;
  typedef struct packed {
    logic       valid;
    logic [4:0] waddr;
  } sb_entry_t;
  function automatic logic sb_hit(sb_entry_t e, logic [4:0] a);
    return e.valid && e.waddr == a && a != 5'd0;
  endfunction
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks pending register writes of EX/MEM/WB and flags RAW hazards for ID
//   clk, arst_n          clock, async active-low reset
//   enable               advance the tracker this cycle
//   take                 branch/jump taken in MEM: younger entries are flushed
//   id_instr             instruction in ID
//   id_reg_write/dst     write enable and rd/rt select of the ID instruction
//   raw                  ID reads a register still pending in the tracked stages
module hazard_scoreboard
  import cpu_hazard_pkg::*;
#(
  parameter bit RF_WB_BYPASS = 1'b0
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        enable,
  input  logic        take,
  input  logic [31:0] id_instr,
  input  logic        id_reg_write,
  input  logic        id_reg_dst,
  output logic        raw
);
  logic [5:0] opcode;
  logic [4:0] rs, rt, dest;
  logic       rs_used, rt_used;
  logic [2:0] hit;
  logic       unused_bits;
  sb_entry_t  id_e;
  sb_entry_t  sb_q [3];
  assign opcode      = id_instr[31:26];
  assign rs          = id_instr[25:21];
  assign rt          = id_instr[20:16];
  assign dest        = id_reg_dst ? id_instr[15:11] : rt;
  assign rs_used     = opcode != OP_J;
  assign rt_used     = opcode == OP_RTYPE || opcode == OP_BEQ || opcode == OP_SW;
  assign id_e        = {id_reg_write && dest != 5'd0, dest};
  assign unused_bits = ^id_instr[10:0];
  genvar i;
  for (i = 0; i < 3; i++) begin : g_cmp
    assign hit[i] = (rs_used && sb_hit(sb_q[i], rs)) || (rt_used && sb_hit(sb_q[i], rt));
  end
  // with the register file bypass, the WB write is visible to ID in the same cycle
  assign raw = hit[0] | hit[1] | (hit[2] & !RF_WB_BYPASS);
  // index 0 = EX, 1 = MEM, 2 = WB; a stall inserts a bubble into EX
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      sb_q[0] <= '0;
      sb_q[1] <= '0;
      sb_q[2] <= '0;
    end else if (enable) begin
      sb_q[0] <= take || raw ? '0 : id_e;
      sb_q[1] <= take ? '0 : sb_q[0];
      sb_q[2] <= sb_q[1];
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencer: RAW stalls, branch/jump flushes, stall/flush counters
//   clk, arst_n                      clock, async active-low reset
//   enable                           global pipeline run enable
//   id_instr, id_reg_write, id_reg_dst   ID instruction and its write control
//   mem_branch, mem_zero, mem_jump   branch/jump resolution of the MEM instruction
//   pc_hold, if_id_hold, id_ex_bubble    stall controls
//   flush_if_id, flush_id_ex, flush_ex_mem   flush controls
//   hz_state                         action of the previous enabled cycle
//   stall_cnt, flush_cnt             saturating performance counters
module hazard_ctrl
  import cpu_hazard_pkg::*;
#(
  parameter bit RF_WB_BYPASS = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic [31:0]      id_instr,
  input  logic             id_reg_write,
  input  logic             id_reg_dst,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_jump,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             id_ex_bubble,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic      raw, take, stall, act;
  hz_state_t state_q, state_d;
  assign take  = mem_jump | (mem_branch & mem_zero);
  assign stall = raw & !take;
  // controls must be quiet while reset is asserted even if MEM inputs are not
  assign act   = enable & arst_n;
  hazard_scoreboard #(.RF_WB_BYPASS(RF_WB_BYPASS)) u_sb (
    .clk         (clk),
    .arst_n      (arst_n),
    .enable      (enable),
    .take        (take),
    .id_instr    (id_instr),
    .id_reg_write(id_reg_write),
    .id_reg_dst  (id_reg_dst),
    .raw         (raw)
  );
  always_comb begin
    pc_hold      = act & stall;
    if_id_hold   = act & stall;
    id_ex_bubble = act & stall;
    flush_if_id  = act & take;
    flush_id_ex  = act & take;
    flush_ex_mem = act & take;
    state_d      = !enable ? HZ_IDLE : take ? HZ_FLUSH : raw ? HZ_STALL : HZ_RUN;
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state_q   <= HZ_IDLE;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (enable && stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (enable && take && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  assign hz_state = state_q;
endmodule
